// File: rtl/johnson_seq_ctrl.sv
// Command-driven Johnson ring sequencer: steps a (SIZE+1)-bit ring a programmed number of phases.
// Optional macro JOHNSON_SEQ_DIR_EN adds a cmd_dir input selecting forward/reverse stepping.
module johnson_seq_ctrl #(
  parameter int unsigned SIZE  = 7,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
`ifdef JOHNSON_SEQ_DIR_EN
  input  logic             cmd_dir,
`endif
  output logic [0:SIZE]    phase_out,
  output logic [IDX_W-1:0] phase_idx,
  output logic [CNT_W-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             cmd_err
);

  localparam int unsigned NPH = 2 * (SIZE + 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NPH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam logic [1:0] OpStart  = 2'b00;
  localparam logic [1:0] OpPause  = 2'b01;
  localparam logic [1:0] OpResume = 2'b10;
  localparam logic [1:0] OpClear  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [0:SIZE]    phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             acc;
  logic [0:SIZE]    fwd_phase, nxt_phase;
  logic             at_wrap;
  logic [IDX_W-1:0] pop;

  assign cmd_ready = ~r;
  assign acc       = cmd_valid & cmd_ready;
  assign fwd_phase = {~phase_q[SIZE], phase_q[0:SIZE-1]};

`ifdef JOHNSON_SEQ_DIR_EN
  logic          dir_q;
  logic [0:SIZE] rev_phase;

  assign rev_phase = {phase_q[1:SIZE], ~phase_q[0]};
  assign nxt_phase = dir_q ? rev_phase : fwd_phase;
  assign at_wrap   = dir_q ? (phase_idx == '0) : (phase_idx == LastIdx);

  // Direction is latched only by a START that actually launches a sequence.
  always_ff @(posedge clk) begin
    if (r) begin
      dir_q <= 1'b0;
    end else if (acc && cmd_op == OpClear) begin
      dir_q <= 1'b0;
    end else if (acc && cmd_op == OpStart && state_q == StIdle && cmd_count != '0) begin
      dir_q <= cmd_dir;
    end
  end
`else
  assign nxt_phase = fwd_phase;
  assign at_wrap   = (phase_idx == LastIdx);
`endif

  always_comb begin
    pop = '0;
    for (int i = 0; i <= int'(SIZE); i++) begin
      pop = pop + IDX_W'(phase_q[i]);
    end
    if (phase_q[0]) begin
      phase_idx = pop;
    end else if (phase_q == '0) begin
      phase_idx = '0;
    end else begin
      phase_idx = IDX_W'(NPH) - pop;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    // Any accepted command, legal or not, suppresses the step on that edge.
    if (acc) begin
      unique case (cmd_op)
        OpStart: begin
          if (state_q != StIdle) begin
            err_d = 1'b1;
          end else if (cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = cmd_count;
            state_d = StRun;
          end
        end
        OpPause: begin
          if (state_q == StRun) state_d = StHold;
          else err_d = 1'b1;
        end
        OpResume: begin
          if (state_q == StHold) state_d = StRun;
          else err_d = 1'b1;
        end
        OpClear: begin
          state_d = StIdle;
          phase_d = '0;
          rem_d   = '0;
        end
      endcase
    end else if (state_q == StRun) begin
      phase_d = nxt_phase;
      wrap_d  = at_wrap;
      rem_d   = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= StIdle;
      phase_q <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign phase_out = phase_q;
  assign rem       = rem_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: a phase-index model predicts every post-edge output.
module tb_johnson_seq_ctrl;

  localparam int SIZE  = 7;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;
  localparam int NPH   = 2 * (SIZE + 1);

  logic             clk = 1'b0;
  logic             r = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_count = '0;
`ifdef JOHNSON_SEQ_DIR_EN
  logic             cmd_dir = 1'b0;
`endif
  logic [0:SIZE]    phase_out;
  logic [IDX_W-1:0] phase_idx;
  logic [CNT_W-1:0] rem;
  logic             busy, done, wrap, cmd_err;

  johnson_seq_ctrl #(.SIZE(SIZE), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .r         (r),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
`ifdef JOHNSON_SEQ_DIR_EN
    .cmd_dir   (cmd_dir),
`endif
    .phase_out (phase_out),
    .phase_idx (phase_idx),
    .rem       (rem),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int rem;
    bit busy;
    bit done;
    bit wrap;
    bit err;
    bit ready;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: phase is a plain index 0..NPH-1, run state 0=idle 1=run 2=hold.
  int m_st = 0, m_idx = 0, m_rem = 0, m_dir = 0;

  function automatic logic [0:SIZE] pat(input int k);
    logic [0:SIZE] p;
    for (int i = 0; i <= SIZE; i++) p[i] = (k <= SIZE + 1) ? (i < k) : (i >= k - (SIZE + 1));
    return p;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit rr, input bit v, input int op, input int cnt, input bit d);
    exp_t e;
    @(negedge clk);
    r         = rr;
    cmd_valid = v;
    cmd_op    = op[1:0];
    cmd_count = cnt[CNT_W-1:0];
`ifdef JOHNSON_SEQ_DIR_EN
    cmd_dir   = d;
`endif
    e.done = 0;
    e.wrap = 0;
    e.err  = 0;
    if (rr) begin
      m_st = 0; m_idx = 0; m_rem = 0; m_dir = 0;
    end else if (v) begin
      case (op)
        0: if (m_st != 0) e.err = 1;
           else if (cnt == 0) e.done = 1;
           else begin
             m_rem = cnt; m_st = 1;
`ifdef JOHNSON_SEQ_DIR_EN
             m_dir = int'(d);
`endif
           end
        1: if (m_st == 1) m_st = 2; else e.err = 1;
        2: if (m_st == 2) m_st = 1; else e.err = 1;
        default: begin m_st = 0; m_idx = 0; m_rem = 0; m_dir = 0; end
      endcase
    end else if (m_st == 1) begin
      if (m_dir == 0) begin
        e.wrap = (m_idx == NPH - 1);
        m_idx  = (m_idx + 1) % NPH;
      end else begin
        e.wrap = (m_idx == 0);
        m_idx  = (m_idx + NPH - 1) % NPH;
      end
      m_rem--;
      if (m_rem == 0) begin m_st = 0; e.done = 1; end
    end
    e.idx   = m_idx;
    e.rem   = m_rem;
    e.busy  = (m_st != 0);
    e.ready = !rr;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("phase_out", int'(phase_out), int'(pat(e.idx)));
        chk("phase_idx", int'(phase_idx), e.idx);
        chk("rem", int'(rem), e.rem);
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
        chk("wrap", int'(wrap), int'(e.wrap));
        chk("cmd_err", int'(cmd_err), int'(e.err));
        chk("cmd_ready", int'(cmd_ready), int'(e.ready));
      end
    end
  end

  initial begin : driver
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 5, 0);
    step(0, 1, 0, 3, 0);
    idle(4);
    chk("start3_phase", int'(phase_out), int'(8'b11100000));
    chk("start3_idx", int'(phase_idx), 3);
    step(0, 1, 0, 20, 0);
    idle(21);
    chk("start20_phase", int'(phase_out), int'(8'b11111110));
    chk("start20_idx", int'(phase_idx), 7);
    step(0, 1, 0, 10, 0);
    idle(4);
    step(0, 1, 1, 0, 0);
    idle(5);
    step(0, 1, 2, 0, 0);
    idle(7);
    step(0, 1, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 5, 0);
    idle(1);
    step(0, 1, 0, 9, 0);
    step(0, 1, 2, 0, 0);
    idle(5);
    step(0, 1, 1, 0, 0);
    step(0, 1, 2, 0, 0);
    step(0, 1, 0, 8, 0);
    idle(3);
    step(1, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 6, 0);
    idle(2);
    step(0, 1, 1, 0, 0);
    idle(1);
    step(0, 1, 3, 0, 0);
    idle(2);
`ifdef JOHNSON_SEQ_DIR_EN
    step(0, 1, 0, 2, 1);
    idle(3);
    chk("rev_phase", int'(phase_out), int'(8'b00000011));
    chk("rev_idx", int'(phase_idx), 14);
`endif
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 12)), $urandom_range(0, 1) == 1);
    end
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
